// File: rtl/fft_pkg.sv
// Shared types for the R2SDF FFT front-end: fixed-point sample type and controller states.
package fft_pkg;

   typedef logic signed [31:0] fpt;

   localparam int FRAC_BITS = 16;

   localparam fpt FPT_IN_MAX = 32'sd32767;
   localparam fpt FPT_IN_MIN = -32'sd32768;
   localparam fpt FPT_SAT_HI = 32'sh7FFF_0000;
   localparam fpt FPT_SAT_LO = 32'sh8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/fpt_convert.sv
// Integer-to-Q16.16 conversion. Define R2SDF_CTRL_SAT_EN to clamp out-of-range inputs
// instead of letting the shift wrap.
module fpt_convert
   import fft_pkg::*;
(
   input  fpt   din_i,
   output fpt   dout_o,
   output logic sat_o
);

`ifdef R2SDF_CTRL_SAT_EN
   // Clamp to the largest representable integer part before shifting.
   always_comb begin
      if (din_i > FPT_IN_MAX) begin
         dout_o = FPT_SAT_HI;
         sat_o  = 1'b1;
      end else if (din_i < FPT_IN_MIN) begin
         dout_o = FPT_SAT_LO;
         sat_o  = 1'b1;
      end else begin
         dout_o = din_i << FRAC_BITS;
         sat_o  = 1'b0;
      end
   end
`else
   assign dout_o = din_i << FRAC_BITS;
   assign sat_o  = 1'b0;
`endif

endmodule

// File: rtl/r2sdf_ctrl.sv
// Sample intake, stage-select and flush sequencer for a radix-2 SDF FFT pipeline.
// Conversion saturation is enabled with `define R2SDF_CTRL_SAT_EN (see fpt_convert).
module r2sdf_ctrl
   import fft_pkg::*;
#(
   parameter int LENGTH   = 8,
   parameter int LOG2_LEN = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_data,
   output logic                dp_valid,
   output logic [31:0]         dp_data,
   output logic [LOG2_LEN-1:0] bf_sel,
   output logic                out_valid,
   output logic                out_last,
   output logic                sat_flag
);

   localparam logic [LOG2_LEN-1:0] LAST_IDX  = LOG2_LEN'(LENGTH - 1);
   localparam logic [LOG2_LEN-1:0] FLUSH_END = LOG2_LEN'(LENGTH - 2);
   localparam logic [LOG2_LEN-1:0] ONE       = LOG2_LEN'(1);

   state_e              state_q, state_d;
   logic [LOG2_LEN-1:0] cnt_q, cnt_d, fill_q, fill_d, oidx_q, oidx_d;
   logic [LOG2_LEN-1:0] bf_sel_q, bf_sel_d, cnt_rev_s;
   fpt                  dp_data_q, dp_data_d, conv_s;
   logic                dp_valid_q, dp_valid_d, out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d, sat_q, sat_d;
   logic                in_ready_s, inject_s, accept_s, advance_s, flush_done_s, conv_sat_s;

   fpt_convert u_conv (
      .din_i  (in_data),
      .dout_o (conv_s),
      .sat_o  (conv_sat_s)
   );

   assign accept_s     = in_valid & in_ready_s;
   assign advance_s    = accept_s | inject_s;
   // Flush reuses cnt: it restarts at 0 on the frame boundary, so LENGTH-1 injects end at LENGTH-2.
   assign flush_done_s = inject_s & (cnt_q == FLUSH_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept_s) state_d = ST_RUN; else state_d = ST_IDLE;
         ST_RUN:   if (!accept_s && (cnt_q == '0)) state_d = ST_FLUSH; else state_d = ST_RUN;
         ST_FLUSH: if (flush_done_s) state_d = ST_IDLE; else state_d = ST_FLUSH;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready_s = 1'b1;
      inject_s   = 1'b0;
      case (state_q)
         ST_FLUSH: begin
            in_ready_s = 1'b0;
            inject_s   = 1'b1;
         end
         default: begin
            in_ready_s = 1'b1;
            inject_s   = 1'b0;
         end
      endcase
   end

   // Stage s takes its select from counter bit LOG2_LEN-1-s.
   always_comb begin
      cnt_rev_s = '0;
      for (int s = 0; s < LOG2_LEN; s++) begin
         cnt_rev_s[s] = cnt_q[LOG2_LEN-1-s];
      end
   end

   always_comb begin
      cnt_d       = cnt_q;
      fill_d      = fill_q;
      oidx_d      = oidx_q;
      bf_sel_d    = bf_sel_q;
      dp_data_d   = dp_data_q;
      dp_valid_d  = advance_s;
      out_valid_d = advance_s & (fill_q == LAST_IDX);
      out_last_d  = out_valid_d & (oidx_q == LAST_IDX);
      sat_d       = sat_q | (accept_s & conv_sat_s);
      if (advance_s) begin
         cnt_d     = cnt_q + ONE;
         fill_d    = (fill_q == LAST_IDX) ? fill_q : fill_q + ONE;
         oidx_d    = out_valid_d ? oidx_q + ONE : oidx_q;
         bf_sel_d  = cnt_rev_s;
         dp_data_d = accept_s ? conv_s : '0;
      end else begin
         cnt_d = cnt_q;
      end
      if (flush_done_s) begin
         cnt_d  = '0;
         fill_d = '0;
         oidx_d = '0;
      end else begin
         fill_d = fill_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         fill_q      <= '0;
         oidx_q      <= '0;
         bf_sel_q    <= '0;
         dp_data_q   <= '0;
         dp_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         fill_q      <= fill_d;
         oidx_q      <= oidx_d;
         bf_sel_q    <= bf_sel_d;
         dp_data_q   <= dp_data_d;
         dp_valid_q  <= dp_valid_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         sat_q       <= sat_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign dp_valid  = dp_valid_q;
   assign dp_data   = dp_data_q;
   assign bf_sel    = bf_sel_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign sat_flag  = sat_q;

endmodule
